// File: rtl/ctrl_pkg.sv
// Shared types and constants for the RV32IM multi-cycle control unit.
package ctrl_pkg;

    typedef enum logic [3:0] {
        AluAdd    = 4'b0000,
        AluSub    = 4'b0001,
        AluSll    = 4'b0010,
        AluSlt    = 4'b0011,
        AluSltu   = 4'b0100,
        AluXor    = 4'b0101,
        AluSrl    = 4'b0110,
        AluSra    = 4'b0111,
        AluOr     = 4'b1000,
        AluAnd    = 4'b1001,
        AluLui    = 4'b1010,
        AluMul    = 4'b1011,
        AluMulh   = 4'b1100,
        AluMulhsu = 4'b1101,
        AluMulhu  = 4'b1110,
        AluDiv    = 4'b1111
    } alu_op_e;

    typedef enum logic [2:0] {
        WbAlu  = 3'b000,
        WbMem  = 3'b001,
        WbPc4  = 3'b010,
        WbCsr  = 3'b011,
        WbDiv  = 3'b100,
        WbGemm = 3'b101
    } wr_bck_e;

    // Immediate format selected by sign_extend.
    localparam logic [2:0] ImmNone = 3'b000;
    localparam logic [2:0] ImmI    = 3'b001;
    localparam logic [2:0] ImmS    = 3'b010;
    localparam logic [2:0] ImmB    = 3'b011;
    localparam logic [2:0] ImmU    = 3'b100;
    localparam logic [2:0] ImmJ    = 3'b101;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpSystem = 7'b1110011;

    typedef struct packed {
        logic [3:0] alu_con;
        logic       reg_wr;
        logic       mem_read;
        logic       mem_write;
        logic       alu_mux_1;    // 1: operand A is PC
        logic       alu_mux_2;    // 1: operand B is immediate
        logic       pc_jump_mux;  // 1: unconditional jump target
        logic [2:0] wr_bck_mux;
        logic [2:0] sign_extend;
        logic [2:0] func3_to_mem;
        logic [2:0] branch_type;  // 0 none, 1..6 BEQ,BNE,BLT,BGE,BLTU,BGEU
        logic       csr_reg_rd;
        logic       csr_reg_wr;
        logic       csr_return;
    } ctrl_t;

    typedef enum logic [1:0] {
        ClsSingle = 2'd0,
        ClsMul    = 2'd1,
        ClsDiv    = 2'd2,
        ClsGemm   = 2'd3
    } instr_class_e;

    typedef logic [1:0] state_e;
    localparam state_e StIdle     = 2'd0;
    localparam state_e StMulWait  = 2'd1;
    localparam state_e StDivWait  = 2'd2;
    localparam state_e StGemmWait = 2'd3;

    // Register/register ALU op for func7 = 0000000 (also ADDI/SLTI/.. by func3).
    function automatic logic [3:0] alu_rr(input logic [2:0] func3);
        logic [3:0] op;
        case (func3)
            3'b000:  op = AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32IM + GEMM decoder: instruction -> control vector, class, illegal flag.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter logic [6:0] GEMM_OPCODE = 7'b0001011
) (
    input  logic [31:0]  instr,
    output ctrl_t        ctrl,
    output instr_class_e iclass,
    output logic         illegal
);

    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;

    assign opcode = instr[6:0];
    assign func3  = instr[14:12];
    assign func7  = instr[31:25];

    // Register indices are consumed by the datapath, not here.
    logic unused_regs;
    assign unused_regs = ^{instr[19:15], instr[11:7]};

    // Decode by opcode; any illegal encoding collapses the vector to zero.
    always_comb begin
        ctrl    = '0;
        iclass  = ClsSingle;
        illegal = 1'b0;
        if (opcode == GEMM_OPCODE) begin
            iclass          = ClsGemm;
            ctrl.reg_wr     = 1'b1;
            ctrl.wr_bck_mux = WbGemm;
        end else begin
            case (opcode)
                OpReg: begin
                    ctrl.reg_wr = 1'b1;
                    case (func7)
                        7'b0000000: ctrl.alu_con = alu_rr(func3);
                        7'b0100000: begin
                            if (func3 == 3'b000)      ctrl.alu_con = AluSub;
                            else if (func3 == 3'b101) ctrl.alu_con = AluSra;
                            else                      illegal = 1'b1;
                        end
                        7'b0000001: begin
                            if (!func3[2]) begin
                                iclass = ClsMul;
                                case (func3[1:0])
                                    2'b00:   ctrl.alu_con = AluMul;
                                    2'b01:   ctrl.alu_con = AluMulh;
                                    2'b10:   ctrl.alu_con = AluMulhsu;
                                    default: ctrl.alu_con = AluMulhu;
                                endcase
                            end else begin
                                iclass          = ClsDiv;
                                ctrl.alu_con    = AluDiv;
                                ctrl.wr_bck_mux = WbDiv;
                            end
                        end
                        default: illegal = 1'b1;
                    endcase
                end
                OpImm: begin
                    ctrl.reg_wr      = 1'b1;
                    ctrl.alu_mux_2   = 1'b1;
                    ctrl.sign_extend = ImmI;
                    if (func3 == 3'b001) begin
                        if (func7 == 7'b0000000) ctrl.alu_con = AluSll;
                        else                     illegal = 1'b1;
                    end else if (func3 == 3'b101) begin
                        if (func7 == 7'b0000000)      ctrl.alu_con = AluSrl;
                        else if (func7 == 7'b0100000) ctrl.alu_con = AluSra;
                        else                          illegal = 1'b1;
                    end else begin
                        ctrl.alu_con = alu_rr(func3);
                    end
                end
                OpLui: begin
                    ctrl.reg_wr      = 1'b1;
                    ctrl.alu_con     = AluLui;
                    ctrl.alu_mux_2   = 1'b1;
                    ctrl.sign_extend = ImmU;
                end
                OpAuipc: begin
                    ctrl.reg_wr      = 1'b1;
                    ctrl.alu_mux_1   = 1'b1;
                    ctrl.alu_mux_2   = 1'b1;
                    ctrl.sign_extend = ImmU;
                end
                OpJal: begin
                    ctrl.reg_wr      = 1'b1;
                    ctrl.wr_bck_mux  = WbPc4;
                    ctrl.pc_jump_mux = 1'b1;
                    ctrl.alu_mux_1   = 1'b1;
                    ctrl.alu_mux_2   = 1'b1;
                    ctrl.sign_extend = ImmJ;
                end
                OpJalr: begin
                    if (func3 != 3'b000) begin
                        illegal = 1'b1;
                    end else begin
                        ctrl.reg_wr      = 1'b1;
                        ctrl.wr_bck_mux  = WbPc4;
                        ctrl.pc_jump_mux = 1'b1;
                        ctrl.alu_mux_2   = 1'b1;
                        ctrl.sign_extend = ImmI;
                    end
                end
                OpBranch: begin
                    ctrl.sign_extend = ImmB;
                    case (func3)
                        3'b000: begin ctrl.branch_type = 3'd1; ctrl.alu_con = AluSub;  end
                        3'b001: begin ctrl.branch_type = 3'd2; ctrl.alu_con = AluSub;  end
                        3'b100: begin ctrl.branch_type = 3'd3; ctrl.alu_con = AluSlt;  end
                        3'b101: begin ctrl.branch_type = 3'd4; ctrl.alu_con = AluSlt;  end
                        3'b110: begin ctrl.branch_type = 3'd5; ctrl.alu_con = AluSltu; end
                        3'b111: begin ctrl.branch_type = 3'd6; ctrl.alu_con = AluSltu; end
                        default: illegal = 1'b1;
                    endcase
                end
                OpLoad: begin
                    if (func3 == 3'b011 || func3 == 3'b110 || func3 == 3'b111) begin
                        illegal = 1'b1;
                    end else begin
                        ctrl.reg_wr       = 1'b1;
                        ctrl.mem_read     = 1'b1;
                        ctrl.wr_bck_mux   = WbMem;
                        ctrl.alu_mux_2    = 1'b1;
                        ctrl.sign_extend  = ImmI;
                        ctrl.func3_to_mem = func3;
                    end
                end
                OpStore: begin
                    if (func3 >= 3'b011) begin
                        illegal = 1'b1;
                    end else begin
                        ctrl.mem_write    = 1'b1;
                        ctrl.alu_mux_2    = 1'b1;
                        ctrl.sign_extend  = ImmS;
                        ctrl.func3_to_mem = func3;
                    end
                end
                OpSystem: begin
                    if (func3 == 3'b001) begin
                        ctrl.reg_wr     = 1'b1;
                        ctrl.wr_bck_mux = WbCsr;
                        ctrl.csr_reg_rd = 1'b1;
                        ctrl.csr_reg_wr = 1'b1;
                    end else if (func3 == 3'b000 && instr[31:20] == 12'h302) begin
                        ctrl.csr_return = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                default: illegal = 1'b1;
            endcase
        end
        if (illegal) begin
            ctrl   = '0;
            iclass = ClsSingle;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Registered, handshaked control unit: accepts one instruction per handshake and
// sequences MUL latency, external divider and GEMM accelerator with timeout.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT      = 2,
    parameter int unsigned GEMM_TIMEOUT = 1024,
    parameter logic [6:0]  GEMM_OPCODE  = 7'b0001011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic        ctrl_valid,
    output ctrl_t       ctrl,
    output logic        illegal,
    output logic        div_start,
    output logic [1:0]  div_op,
    input  logic        div_done,
    output logic        gemm_start,
    input  logic        gemm_done,
    output logic        gemm_timeout
);

    localparam int unsigned CntMax = (MUL_LAT > GEMM_TIMEOUT) ? MUL_LAT : GEMM_TIMEOUT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] MulLast  = CntW'(MUL_LAT - 1);
    localparam logic [CntW-1:0] GemmLast = CntW'(GEMM_TIMEOUT - 1);

    ctrl_t        dec_ctrl;
    instr_class_e dec_class;
    logic         dec_illegal;

    ctrl_decode #(
        .GEMM_OPCODE (GEMM_OPCODE)
    ) u_decode (
        .instr   (instr),
        .ctrl    (dec_ctrl),
        .iclass  (dec_class),
        .illegal (dec_illegal)
    );

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    ctrl_t           pend_q, pend_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic            ctrl_valid_q, ctrl_valid_d;
    logic            illegal_q, illegal_d;
    logic            div_start_q, div_start_d;
    logic [1:0]      div_op_q, div_op_d;
    logic            gemm_start_q, gemm_start_d;
    logic            gemm_timeout_q, gemm_timeout_d;
    logic            accept;

    assign instr_ready = (state_q == StIdle) && !rst;
    assign accept      = instr_valid && instr_ready;

    // Next-state: pulses default low, ctrl is only non-zero alongside ctrl_valid.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pend_d         = pend_q;
        div_op_d       = div_op_q;
        ctrl_d         = '0;
        ctrl_valid_d   = 1'b0;
        illegal_d      = 1'b0;
        div_start_d    = 1'b0;
        gemm_start_d   = 1'b0;
        gemm_timeout_d = 1'b0;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (dec_illegal) begin
                            illegal_d = 1'b1;
                        end else begin
                            case (dec_class)
                                ClsMul: begin
                                    if (MUL_LAT == 1) begin
                                        ctrl_valid_d = 1'b1;
                                        ctrl_d       = dec_ctrl;
                                    end else begin
                                        state_d = StMulWait;
                                        cnt_d   = CntW'(1);
                                        pend_d  = dec_ctrl;
                                    end
                                end
                                ClsDiv: begin
                                    state_d     = StDivWait;
                                    div_start_d = 1'b1;
                                    div_op_d    = instr[13:12];
                                    pend_d      = dec_ctrl;
                                end
                                ClsGemm: begin
                                    state_d      = StGemmWait;
                                    gemm_start_d = 1'b1;
                                    cnt_d        = '0;
                                    pend_d       = dec_ctrl;
                                end
                                default: begin
                                    ctrl_valid_d = 1'b1;
                                    ctrl_d       = dec_ctrl;
                                end
                            endcase
                        end
                    end
                end
                StMulWait: begin
                    // cnt_q holds cycles elapsed since accept.
                    if (cnt_q == MulLast) begin
                        state_d      = StIdle;
                        cnt_d        = '0;
                        ctrl_valid_d = 1'b1;
                        ctrl_d       = pend_q;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StDivWait: begin
                    // div_start_q marks the first wait cycle, where div_done is stale.
                    if (div_done && !div_start_q) begin
                        state_d      = StIdle;
                        ctrl_valid_d = 1'b1;
                        ctrl_d       = pend_q;
                    end
                end
                StGemmWait: begin
                    if (gemm_done) begin
                        state_d      = StIdle;
                        cnt_d        = '0;
                        ctrl_valid_d = 1'b1;
                        ctrl_d       = pend_q;
                    end else if (cnt_q == GemmLast) begin
                        state_d        = StIdle;
                        cnt_d          = '0;
                        gemm_timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            pend_q         <= '0;
            ctrl_q         <= '0;
            ctrl_valid_q   <= 1'b0;
            illegal_q      <= 1'b0;
            div_start_q    <= 1'b0;
            div_op_q       <= 2'b00;
            gemm_start_q   <= 1'b0;
            gemm_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pend_q         <= pend_d;
            ctrl_q         <= ctrl_d;
            ctrl_valid_q   <= ctrl_valid_d;
            illegal_q      <= illegal_d;
            div_start_q    <= div_start_d;
            div_op_q       <= div_op_d;
            gemm_start_q   <= gemm_start_d;
            gemm_timeout_q <= gemm_timeout_d;
        end
    end

    assign ctrl         = ctrl_q;
    assign ctrl_valid   = ctrl_valid_q;
    assign illegal      = illegal_q;
    assign div_start    = div_start_q;
    assign div_op       = div_op_q;
    assign gemm_start   = gemm_start_q;
    assign gemm_timeout = gemm_timeout_q;

endmodule
